// File: rtl/nwc_stage_agu.sv
// Address/control sequencer for one in-place radix-2 negacyclic NTT stage.
// Issues butterfly read pairs and delays them to produce write-back strobes.
module nwc_stage_agu #(
  parameter int N      = 16,
  parameter int LOG_N  = $clog2(N),
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 2,
  // one extra bit so an out-of-range stage can be requested and flagged
  localparam int SW    = $clog2(LOG_N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW-1:0]    stage,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int L  = RD_LAT + BU_LAT;
  localparam int PW = 2 * LOG_N + 1;
  localparam logic [LOG_N-1:0] HALF = LOG_N'(N / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] ra_q, ra_d;
  logic [LOG_N-1:0] rb_q, rb_d;
  logic [LOG_N-1:0] tw_q, tw_d;
  logic [PW-1:0]    pipe_q [L];
  logic [PW-1:0]    pipe_d [L];

  logic             go, bad, drained, issue;
  logic [SW-1:0]    s_sel;
  logic [LOG_N-1:0] k_sel, t_v, i_v, off_v, a_v;
  int               sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
      for (int j = 0; j < L; j++) pipe_q[j] <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tw_q    <= tw_d;
      for (int j = 0; j < L; j++) pipe_q[j] <= pipe_d[j];
    end
  end

  // only the final pipeline slot may still hold a write when we leave DRAIN
  always_comb begin
    drained = 1'b1;
    for (int j = 0; j < L - 1; j++)
      if (pipe_q[j][PW-1]) drained = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    go      = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(stage) < LOG_N) begin
            go      = 1'b1;
            s_d     = stage;
            k_d     = LOG_N'(1);
            state_d = ISSUE;
          end else begin
            bad = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (k_q == HALF) state_d = DRAIN;
        else k_d = k_q + LOG_N'(1);
      end
      DRAIN: begin
        if (drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_sel   = go ? stage : s_q;
    k_sel   = go ? '0 : k_q;
    sh      = LOG_N - 1 - int'(s_sel);
    t_v     = LOG_N'(1) << sh;
    i_v     = k_sel >> sh;
    off_v   = k_sel & (t_v - LOG_N'(1));
    a_v     = (i_v << (sh + 1)) | off_v;
    issue   = go | (state_q == ISSUE && k_q != HALF);
    rd_en_d = issue;
    ra_d    = issue ? a_v : '0;
    rb_d    = issue ? a_v + t_v : '0;
    tw_d    = issue ? (LOG_N'(1) << s_sel) + i_v : '0;
    busy_d  = state_d != IDLE;
    done_d  = state_q == DRAIN && drained;
    err_d   = bad;
    pipe_d[0] = {rd_en_q, ra_q, rb_q};
    for (int j = 1; j < L; j++) pipe_d[j] = pipe_q[j-1];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign wr_en     = pipe_q[L-1][PW-1];
  assign wr_addr_a = pipe_q[L-1][2*LOG_N-1:LOG_N];
  assign wr_addr_b = pipe_q[L-1][LOG_N-1:0];

endmodule

// File: tb/tb_nwc_stage_agu.sv
// Bench for nwc_stage_agu: per-cycle comparison of all outputs against
// a butterfly-loop reference of one NTT stage.
module tb_nwc_stage_agu;

  localparam int N      = 16;
  localparam int LOG_N  = 4;
  localparam int RD_LAT = 1;
  localparam int BU_LAT = 2;
  localparam int L      = RD_LAT + BU_LAT;
  localparam int SW     = $clog2(LOG_N) + 1;
  localparam int VW     = 5 + 5 * LOG_N;
  localparam int LAST   = N / 2 + L + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [SW-1:0]    stage = '0;
  logic             busy, done, err, rd_en, wr_en;
  logic [LOG_N-1:0] rd_addr_a, rd_addr_b, tw_addr;
  logic [LOG_N-1:0] wr_addr_a, wr_addr_b;

  int checks = 0;
  int failures = 0;

  nwc_stage_agu #(
    .N(N), .LOG_N(LOG_N), .RD_LAT(RD_LAT), .BU_LAT(BU_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] got = {busy, done, err, rd_en, rd_addr_a, rd_addr_b,
                       tw_addr, wr_en, wr_addr_a, wr_addr_b};

  // expected outputs in cycle c after the start cycle of stage s
  function automatic logic [VW-1:0] exp_vec(int s, int c);
    int ea [N/2];
    int eb [N/2];
    int et [N/2];
    int idx = 0;
    int m = 1 << s;
    int t = N / (2 * m);
    logic b, d, r, w;
    logic [LOG_N-1:0] ra, rb, tw, wa, wb;
    for (int i = 0; i < m; i++)
      for (int j = 2 * i * t; j < 2 * i * t + t; j++) begin
        ea[idx] = j;
        eb[idx] = j + t;
        et[idx] = m + i;
        idx++;
      end
    b = (c >= 1 && c <= N / 2 + L);
    d = (c == N / 2 + L + 1);
    r = (c >= 1 && c <= N / 2);
    w = (c >= L + 1 && c <= N / 2 + L);
    ra = r ? LOG_N'(ea[c-1]) : '0;
    rb = r ? LOG_N'(eb[c-1]) : '0;
    tw = r ? LOG_N'(et[c-1]) : '0;
    wa = w ? LOG_N'(ea[c-1-L]) : '0;
    wb = w ? LOG_N'(eb[c-1-L]) : '0;
    return {b, d, 1'b0, r, ra, rb, tw, w, wa, wb};
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL %s idle cycle %0d got=%h exp=0", tag, c, got);
      end
    end
  endtask

  // start must already be driven for cycle c0; optionally chain or poke start
  task automatic check_run(input int s, input int next_s, input int poke_at);
    logic [VW-1:0] e;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_vec(s, c);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL run s=%0d cycle %0d got=%h exp=%h", s, c, got, e);
      end
      if (c == poke_at) begin
        start = 1'b1;
        stage = SW'($urandom_range(0, LOG_N - 1));
      end
      if (c == LAST && next_s >= 0) begin
        start = 1'b1;
        stage = SW'(next_s);
      end
    end
  endtask

  task automatic kick(input int s);
    @(negedge clk);
    start = 1'b1;
    stage = SW'(s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL reset got=%h exp=0", got);
      end
    end
    rst = 1'b0;
    start = 1'b1;
    stage = '0;
    check_run(0, -1, -1);
    idle_check("after_s0", 2);
  endtask

  task automatic test_stages();
    for (int s = 1; s < LOG_N; s++) begin
      kick(s);
      check_run(s, -1, -1);
      idle_check("after_stage", 2);
    end
  endtask

  task automatic test_err();
    for (int r = 0; r < 3; r++) begin
      kick(r == 0 ? LOG_N : int'($urandom_range(LOG_N, (1 << SW) - 1)));
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (got !== {3'b001, (VW - 3)'(0)}) begin
        failures++;
        $display("FAIL err_pulse got=%h exp=%h", got,
                 {3'b001, (VW - 3)'(0)});
      end
      idle_check("after_err", 3);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] e;
    kick(2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_vec(2, c);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL pre_rst cycle %0d got=%h exp=%h", c, got, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL mid_rst got=%h exp=0", got);
    end
    rst = 1'b0;
    idle_check("post_rst", N / 2 + L + 2);
    kick(2);
    check_run(2, -1, -1);
    idle_check("after_rerun", 2);
  endtask

  task automatic test_busy_start();
    kick(1);
    check_run(1, -1, 3);
    kick(3);
    check_run(3, -1, N / 2 + 2);
    idle_check("after_busy_start", 2);
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2;
    s0 = int'($urandom_range(0, LOG_N - 1));
    s1 = int'($urandom_range(0, LOG_N - 1));
    s2 = int'($urandom_range(0, LOG_N - 1));
    kick(s0);
    check_run(s0, s1, -1);
    check_run(s1, s2, -1);
    check_run(s2, -1, -1);
    idle_check("after_b2b", 2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int s = int'($urandom_range(0, LOG_N - 1));
      idle_check("rand_gap", int'($urandom_range(0, 3)));
      kick(s);
      check_run(s, -1, -1);
    end
    idle_check("after_rand", 2);
  endtask

  initial begin
    test_reset();
    test_stages();
    test_err();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
